// File: rtl/req_encoder42_pkg.sv
// Shared types and constants for the 4-to-2 request encoder.
// Holds the FSM state encoding and the code <-> one-hot helper.
package req_encoder42_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    return N_REQ'(1) << code;
  endfunction

endpackage

// File: rtl/req_encoder42_if.sv
// Request/offer bundle between a request source and req_encoder42.
// The master side drives requests and the handshake; the slave side offers codes.
interface req_encoder42_if
  import req_encoder42_pkg::*;
;
  logic [N_REQ-1:0]  req;
  logic              ready;
  logic              ovf_clr;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic [N_REQ-1:0]  pending;
  logic              overflow;

  modport master (
    output req, ready, ovf_clr,
    input  code, valid, pending, overflow
  );

  modport slave (
    input  req, ready, ovf_clr,
    output code, valid, pending, overflow
  );
endinterface

// File: rtl/req_encoder42_prio.sv
// Fixed-priority selector: index of the highest set bit, plus an any-set flag.
module prio_enc42
  import req_encoder42_pkg::*;
(
  input  logic [N_REQ-1:0]  req_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    // Ascending scan: the last set bit seen (the highest index) wins.
    for (int i = 0; i < N_REQ; i++) begin
      if (req_i[i]) idx_o = CODE_W'(i);
    end
  end

endmodule

// File: rtl/req_encoder42.sv
// Pending-request encoder: captures one-hot requests and offers them one
// binary code per cycle, highest index first, over a valid/ready handshake.
module req_encoder42
  import req_encoder42_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  req_encoder42_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic              overflow_q, overflow_d;

  logic              accept;
  logic              ovf_event;
  logic [N_REQ-1:0]  served;
  logic [N_REQ-1:0]  prio_in;
  logic [CODE_W-1:0] prio_idx;
  logic              prio_any;

  always_comb begin
    accept     = valid_q && bus.ready;
    served     = accept ? code_to_onehot(code_q) : '0;
    pending_d  = (pending_q & ~served) | bus.req;
    // A request on the bit just served is a fresh request, not an overflow.
    ovf_event  = |(bus.req & pending_q & ~served);
    overflow_d = ovf_event | (overflow_q & ~bus.ovf_clr);
  end

  // From IDLE the offer comes from what is already pending; after an accept
  // the next code is chosen from the post-accept pending value.
  assign prio_in = (state_q == IDLE) ? pending_q : pending_d;

  prio_enc42 u_prio (
    .req_i (prio_in),
    .idx_o (prio_idx),
    .any_o (prio_any)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (prio_any) begin
          state_d = OFFER;
          code_d  = prio_idx;
        end
      end
      OFFER: begin
        if (accept) begin
          if (prio_any) code_d  = prio_idx;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == OFFER);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      code_q     <= '0;
      valid_q    <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.code     = code_q;
  assign bus.valid    = valid_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_req_encoder42.sv
// Self-checking bench for req_encoder42: directed scenarios plus random
// traffic, all compared against a per-edge behavioural model.
module tb_req_encoder42;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  req_encoder42_if bus ();

  req_encoder42 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: set of pending requests, current offer, sticky flag.
  bit [3:0] m_pend;
  bit       m_valid;
  int       m_code;
  bit       m_ovf;

  function automatic int highest(input bit [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_code  = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge(input bit [3:0] r, input bit rd, input bit oc);
    bit [3:0] nxt;
    bit       evt;
    bit       keep;
    int       srv;
    srv = (m_valid && rd) ? m_code : -1;
    nxt = '0;
    evt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      keep = m_pend[i] && (i != srv);
      if (keep && r[i]) evt = 1'b1;
      nxt[i] = keep || r[i];
    end
    if (!m_valid) begin
      if (m_pend != 0) begin
        m_valid = 1'b1;
        m_code  = highest(m_pend);
      end
    end else if (srv >= 0) begin
      if (nxt != 0) m_code  = highest(nxt);
      else          m_valid = 1'b0;
    end
    m_ovf  = evt || (m_ovf && !oc);
    m_pend = nxt;
  endtask

  // Code only matters while valid, so it is masked otherwise.
  function automatic logic [7:0] dut_vec();
    return {bus.valid, (bus.valid ? bus.code : 2'b00), bus.pending, bus.overflow};
  endfunction

  function automatic logic [7:0] mdl_vec();
    return {m_valid, (m_valid ? 2'(m_code) : 2'b00), m_pend, m_ovf};
  endfunction

  task automatic tick(input logic [3:0] r, input logic rd, input logic oc);
    @(negedge clk);
    bus.req     = r;
    bus.ready   = rd;
    bus.ovf_clr = oc;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(r, rd, oc);
    #1;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({bus.valid, bus.code, bus.pending, bus.overflow} !== 8'h00) begin
      n_err++;
      $display("FAIL reset: got %b exp %b", {bus.valid, bus.code, bus.pending, bus.overflow}, 8'h00);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] r [3] = '{4'b0100, 4'b0000, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      tick(r[i], 1'b1, 1'b0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL single[%0d]: got %b exp %b", i, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin
      n_err++;
      $display("FAIL single_end: got valid=%b pending=%b exp valid=0 pending=0000", bus.valid, bus.pending);
    end
  endtask

  task automatic test_drain();
    logic [1:0] exp_c [3] = '{2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 5; i++) begin
      tick((i == 0) ? 4'b1011 : 4'b0000, 1'b1, 1'b0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL drain[%0d]: got %b exp %b", i, dut_vec(), mdl_vec());
      end
      if (i >= 1 && i <= 3) begin
        n_vec++;
        if (bus.valid !== 1'b1 || bus.code !== exp_c[i-1]) begin
          n_err++;
          $display("FAIL drain_code[%0d]: got valid=%b code=%b exp valid=1 code=%b", i, bus.valid, bus.code, exp_c[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [3:0] r  [6] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic       rd [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] ec [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00};
    for (int i = 0; i < 6; i++) begin
      tick(r[i], rd[i], 1'b0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL stall[%0d]: got %b exp %b", i, dut_vec(), mdl_vec());
      end
      if (i >= 1 && i <= 4) begin
        n_vec++;
        if (bus.valid !== 1'b1 || bus.code !== ec[i]) begin
          n_err++;
          $display("FAIL stall_code[%0d]: got valid=%b code=%b exp valid=1 code=%b", i, bus.valid, bus.code, ec[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [3:0] r  [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
    logic       rd [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       oc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick(r[i], rd[i], oc[i]);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL overflow[%0d]: got %b exp %b", i, dut_vec(), mdl_vec());
      end
      if (i == 1) begin
        n_vec++;
        if (bus.overflow !== 1'b1 || bus.pending !== 4'b0010) begin
          n_err++;
          $display("FAIL overflow_set: got ovf=%b pending=%b exp ovf=1 pending=0010", bus.overflow, bus.pending);
        end
      end
      if (i == 2) begin
        n_vec++;
        if (bus.overflow !== 1'b0) begin
          n_err++;
          $display("FAIL overflow_clr: got ovf=%b exp ovf=0", bus.overflow);
        end
      end
    end
  endtask

  task automatic test_serve_rereq();
    logic [3:0] r  [4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    logic       rd [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tick(r[i], rd[i], 1'b0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL rereq[%0d]: got %b exp %b", i, dut_vec(), mdl_vec());
      end
      if (i == 2) begin
        n_vec++;
        if ({bus.valid, bus.code, bus.pending, bus.overflow} !== 8'b1_00_0001_0) begin
          n_err++;
          $display("FAIL rereq_keep: got %b exp %b", {bus.valid, bus.code, bus.pending, bus.overflow}, 8'b1_00_0001_0);
        end
      end
    end
  endtask

  task automatic test_ovf_coincide();
    logic [3:0] r  [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic       rd [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       oc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick(r[i], rd[i], oc[i]);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL coincide[%0d]: got %b exp %b", i, dut_vec(), mdl_vec());
      end
      if (i == 1) begin
        n_vec++;
        if (bus.overflow !== 1'b1) begin
          n_err++;
          $display("FAIL coincide_set: got ovf=%b exp ovf=1", bus.overflow);
        end
      end
    end
  endtask

  task automatic test_reset_mid_offer();
    tick(4'b1100, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    n_vec++;
    if ({bus.valid, bus.code, bus.pending} !== 7'b1_11_1100) begin
      n_err++;
      $display("FAIL midrst_pre: got %b exp %b", {bus.valid, bus.code, bus.pending}, 7'b1_11_1100);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({bus.valid, bus.code, bus.pending, bus.overflow} !== 8'h00) begin
      n_err++;
      $display("FAIL midrst_async: got %b exp %b", {bus.valid, bus.code, bus.pending, bus.overflow}, 8'h00);
    end
    tick(4'b1111, 1'b1, 1'b0);
    n_vec++;
    if ({bus.valid, bus.code, bus.pending, bus.overflow} !== 8'h00) begin
      n_err++;
      $display("FAIL midrst_hold: got %b exp %b", {bus.valid, bus.code, bus.pending, bus.overflow}, 8'h00);
    end
    rst = 1'b0;
    tick(4'b0001, 1'b0, 1'b0);
    n_vec++;
    if (bus.pending !== 4'b0001 || bus.valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_first: got pending=%b valid=%b exp pending=0001 valid=0", bus.pending, bus.valid);
    end
    for (int i = 0; i < 2; i++) begin
      tick(4'b0000, 1'b1, 1'b0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL midrst_drain[%0d]: got %b exp %b", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rd;
    logic       oc;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      rd = ($urandom_range(0, 3) != 0);
      oc = ($urandom_range(0, 9) == 0);
      tick(r, rd, oc);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: req=%b rdy=%b clr=%b got %b exp %b", i, r, rd, oc, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    bus.req     = '0;
    bus.ready   = 1'b0;
    bus.ovf_clr = 1'b0;
    #12;
    test_reset();
    test_single();
    test_drain();
    test_stall();
    test_overflow();
    test_serve_rereq();
    test_ovf_coincide();
    test_reset_mid_offer();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
